// File: rtl/word_byte_serializer_pkg.sv
// word_byte_serializer_pkg: state encoding and word/byte constants shared by the serializer slice.
package word_byte_serializer_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_IDX = 2'd3;
endpackage

// File: rtl/word_byte_serializer_if.sv
// word_byte_serializer_if: word input stream, byte output stream and busy status.
interface word_byte_serializer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last, busy);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last, busy);
endinterface

// File: rtl/word_byte_serializer_splitter.sv
// word_byte_serializer_splitter: splits a 32-bit word into its four bytes, O1 most significant.
module word_byte_serializer_splitter (
    input  logic [31:0] A,
    output logic [7:0]  O1,
    output logic [7:0]  O2,
    output logic [7:0]  O3,
    output logic [7:0]  O4
);
    assign {O1, O2, O3, O4} = A;
endmodule

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: holds one accepted word and emits its four bytes one per cycle with a last flag.
module word_byte_serializer
    import word_byte_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic reset_n,
    word_byte_serializer_if.slave bus
);
    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx, sel;
    logic [31:0] word_q, word_nx;
    logic [7:0]  o [BYTES_PER_WORD];
    logic        send, last, load;

    word_byte_serializer_splitter u_split (
        .A (word_q),
        .O1(o[0]),
        .O2(o[1]),
        .O3(o[2]),
        .O4(o[3])
    );

    // LSB-first order walks the splitter outputs backwards
    assign sel = MSB_FIRST ? idx : ~idx;

    always_comb begin
        send          = state == ST_SEND;
        last          = idx == LAST_IDX;
        bus.out_valid = send;
        bus.busy      = send;
        bus.out_last  = send && last;
        bus.out_data  = send ? o[sel] : 8'h00;
        bus.in_ready  = !send || (last && bus.out_ready);
        load          = bus.in_valid && bus.in_ready;
        state_nx      = load ? ST_SEND : (send && last && bus.out_ready) ? ST_IDLE : state;
        idx_nx        = load ? 2'd0 : (send && bus.out_ready) ? idx + 2'd1 : idx;
        word_nx       = load ? bus.in_data : word_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            idx    <= 2'd0;
            word_q <= 32'h0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            word_q <= word_nx;
        end
    end
endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: directed vectors for MSB-first and LSB-first serializer instances.
module tb_word_byte_serializer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    word_byte_serializer_if bm ();
    word_byte_serializer_if bl ();

    word_byte_serializer #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset_n(reset_n), .bus(bm.slave));
    word_byte_serializer #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset_n(reset_n), .bus(bl.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic chk_m(input string tag, input logic v, input logic [7:0] d, input logic l);
        check({tag, " valid"}, {31'd0, bm.out_valid}, {31'd0, v});
        check({tag, " data"}, {24'd0, bm.out_data}, {24'd0, d});
        check({tag, " last"}, {31'd0, bm.out_last}, {31'd0, l});
        check({tag, " busy"}, {31'd0, bm.busy}, {31'd0, v});
    endtask

    task automatic chk_l(input string tag, input logic v, input logic [7:0] d, input logic l);
        check({tag, " valid"}, {31'd0, bl.out_valid}, {31'd0, v});
        check({tag, " data"}, {24'd0, bl.out_data}, {24'd0, d});
        check({tag, " last"}, {31'd0, bl.out_last}, {31'd0, l});
        check({tag, " busy"}, {31'd0, bl.busy}, {31'd0, v});
    endtask

    initial begin
        logic [7:0] b2b [8];
        logic       rdy [8];
        logic [7:0] seq [4];
        b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bm.in_valid = 1'b0; bm.in_data = 32'h0; bm.out_ready = 1'b1;
        bl.in_valid = 1'b0; bl.in_data = 32'h0; bl.out_ready = 1'b1;

        // reset state
        @(negedge clk);
        chk_m("reset m", 1'b0, 8'h00, 1'b0);
        chk_l("reset l", 1'b0, 8'h00, 1'b0);
        check("reset in_ready", {31'd0, bm.in_ready}, 32'd1);
        reset_n = 1'b1;

        // MSB first, 32'd1000
        @(negedge clk);
        bm.in_valid = 1'b1; bm.in_data = 32'd1000;
        check("t2 in_ready idle", {31'd0, bm.in_ready}, 32'd1);
        seq = '{8'h00, 8'h00, 8'h03, 8'hE8};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bm.in_valid = 1'b0;
            chk_m($sformatf("t2 byte%0d", i), 1'b1, seq[i], i == 3);
        end
        @(negedge clk);
        chk_m("t2 idle", 1'b0, 8'h00, 1'b0);

        // backpressure on byte 03
        bm.in_valid = 1'b1; bm.in_data = 32'h0000_03E8;
        @(negedge clk); bm.in_valid = 1'b0; bm.in_data = 32'hFFFF_FFFF;
        chk_m("t3 b0", 1'b1, 8'h00, 1'b0);
        @(negedge clk); chk_m("t3 b1", 1'b1, 8'h00, 1'b0);
        @(negedge clk); chk_m("t3 b2", 1'b1, 8'h03, 1'b0); bm.out_ready = 1'b0;
        check("t3 stall in_ready", {31'd0, bm.in_ready}, 32'd0);
        @(negedge clk); chk_m("t3 hold1", 1'b1, 8'h03, 1'b0);
        @(negedge clk); chk_m("t3 hold2", 1'b1, 8'h03, 1'b0); bm.out_ready = 1'b1;
        @(negedge clk); chk_m("t3 b3", 1'b1, 8'hE8, 1'b1);
        @(negedge clk); chk_m("t3 idle", 1'b0, 8'h00, 1'b0);

        // back-to-back words
        bm.in_valid = 1'b1; bm.in_data = 32'h1122_3344;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bm.in_data = 32'hAABB_CCDD;
            if (i == 4) bm.in_valid = 1'b0;
            chk_m($sformatf("t4 byte%0d", i), 1'b1, b2b[i], rdy[i]);
            check($sformatf("t4 in_ready%0d", i), {31'd0, bm.in_ready}, {31'd0, rdy[i]});
        end
        @(negedge clk); chk_m("t4 idle", 1'b0, 8'h00, 1'b0);

        // LSB first instance
        bl.in_valid = 1'b1; bl.in_data = 32'h1122_3344;
        seq = '{8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bl.in_valid = 1'b0;
            chk_l($sformatf("t5 byte%0d", i), 1'b1, seq[i], i == 3);
        end
        @(negedge clk); chk_l("t5 idle", 1'b0, 8'h00, 1'b0);

        // offered word waits until the last byte is taken
        bm.in_valid = 1'b1; bm.in_data = 32'h0102_0304;
        @(negedge clk); bm.in_valid = 1'b0; chk_m("t6 b0", 1'b1, 8'h01, 1'b0);
        @(negedge clk); bm.in_valid = 1'b1; bm.in_data = 32'hDEAD_BEEF;
        chk_m("t6 b1", 1'b1, 8'h02, 1'b0);
        check("t6 in_ready idx1", {31'd0, bm.in_ready}, 32'd0);
        @(negedge clk); chk_m("t6 b2", 1'b1, 8'h03, 1'b0);
        check("t6 in_ready idx2", {31'd0, bm.in_ready}, 32'd0);
        @(negedge clk); chk_m("t6 b3", 1'b1, 8'h04, 1'b1);
        check("t6 in_ready idx3", {31'd0, bm.in_ready}, 32'd1);
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bm.in_valid = 1'b0;
            chk_m($sformatf("t6 dead%0d", i), 1'b1, seq[i], i == 3);
        end
        @(negedge clk); chk_m("t6 idle", 1'b0, 8'h00, 1'b0);

        // asynchronous reset mid-word
        bm.in_valid = 1'b1; bm.in_data = 32'h1122_3344;
        @(negedge clk); bm.in_valid = 1'b0;
        @(negedge clk); chk_m("t1 pre", 1'b1, 8'h22, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk_m("t1 async", 1'b0, 8'h00, 1'b0);
        check("t1 async in_ready", {31'd0, bm.in_ready}, 32'd1);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_m($sformatf("t1 after%0d", i), 1'b0, 8'h00, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/word_byte_serializer.md
Name: word_byte_serializer

Overview:
- Sequences the 32-bit-to-4-byte splitter datapath.
- Accepts one 32-bit word on a valid/ready input handshake and holds it in a register that feeds a splitter instance.
- Emits the four bytes one per cycle on a valid/ready byte stream, with a last-byte flag.
- Sits between a word producer (register file / bus) and an 8-bit consumer (byte-wide memory or UART-style port).

Parameters:
- MSB_FIRST, 1: 1 emits byte order O1,O2,O3,O4 (bits 31:24 first); 0 emits O4,O3,O2,O1 (bits 7:0 first).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  32  word to serialize.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data holds a valid byte.
- out_data  output  8  current byte.
- out_last  output  1  current byte is the 4th byte of the word.
- out_ready  input  1  consumer takes out_data this cycle.
- busy  output  1  a word is held (state SEND).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, takes effect immediately, no clock needed):
  - state=IDLE, idx=0, word_q=32'h0.
  - out_valid=0, out_data=8'h00, out_last=0, busy=0, in_ready=1.
  - Reset mid-word discards the remaining bytes; no partial output after release.
- Word split (splitter sub-module on word_q): O1=[31:24], O2=[23:16], O3=[15:8], O4=[7:0].
- idx is a 2-bit byte counter.
  - MSB_FIRST=1: idx 0..3 selects O1..O4.
  - MSB_FIRST=0: idx 0..3 selects O4..O1.
- States:
  - IDLE: out_valid=0, out_data=8'h00, in_ready=1. On in_valid at a rising edge: word_q<=in_data, idx<=0, go to SEND.
  - SEND: out_valid=1, busy=1, out_data=selected byte, out_last=(idx==3).
    - out_ready=0: hold everything; out_data stable, no byte skipped.
    - out_ready=1, idx<3: idx<=idx+1.
    - out_ready=1, idx==3, in_valid=1: load next word (word_q<=in_data, idx<=0), stay in SEND.
    - out_ready=1, idx==3, in_valid=0: go to IDLE, idx<=0.
- in_ready = (state==IDLE) || (state==SEND && idx==3 && out_ready).
  - Combinational path from out_ready to in_ready is intentional.
  - in_ready is never asserted while the word is not yet fully drained.
- Latency and throughput:
  - Word accepted at edge N; its first byte is valid during cycle N+1.
  - Minimum 4 cycles per word.
  - Back-to-back words sustain 1 byte/cycle with no bubble.
- in_data is sampled only on an accepted handshake; changes at other times are ignored.
- All outputs are registered or decoded from registered state, except in_ready.

Decomposition:
- Shared package holds:
  - state encoding: ST_IDLE=1'b0, ST_SEND=1'b1.
  - constants BYTES_PER_WORD=4, LAST_IDX=2'd3.
- Sub-module: splitter (existing block, ports A[31:0] -> O1..O4[7:0]), instantiated once on word_q.
- Byte select mux, counter and FSM live in the top module.

Test Plan:
1. Reset: reset_n=0 asserted mid-SEND with no clock edge -> immediately out_valid=0, busy=0, in_ready=1, out_data=8'h00; after release no stale bytes appear.
2. MSB_FIRST=1, in_data=32'd1000 (32'h000003E8), out_ready=1 -> bytes 00,00,03,E8 on 4 consecutive cycles; out_last=1 only with E8; then IDLE.
3. Backpressure: same word, out_ready=0 for 2 cycles while byte 03 is presented -> out_data=03 and out_valid=1 held stable for those cycles; sequence completes 00,00,03,E8 with no loss or duplication.
4. Back-to-back: in_valid held high with 32'h11223344 then 32'hAABBCCDD, out_ready=1 -> 11,22,33,44,AA,BB,CC,DD in 8 consecutive cycles; in_ready=1 only in IDLE and on cycles showing 44 and DD.
5. MSB_FIRST=0, in_data=32'h11223344 -> 44,33,22,11, out_last with 11.
6. in_valid=1 with 32'hDEADBEEF while idx=1 -> in_ready=0, word not consumed; DEADBEEF is accepted exactly in the cycle the current word's last byte is taken.
